// File: rtl/sequence_checker.sv
`default_nettype none
// ============================================================================
// sequence_checker : lock/predict monitor for the 101->110->011->001 stream
// Rev 1.0
// ============================================================================
module sequence_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       seq_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       expected
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_C  = 4'(LOSS_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Successor of a legal code; illegal codes map to 000, which doubles as the legality test.
    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b101:  succ = 3'b110;
            3'b110:  succ = 3'b011;
            3'b011:  succ = 3'b001;
            3'b001:  succ = 3'b101;
            default: succ = 3'b000;
        endcase
    endfunction

    state_t           state, state_n;
    logic [3:0]       good, good_n;
    logic [3:0]       bad, bad_n;
    logic [2:0]       expected_n;
    logic [ERR_W-1:0] err_count_n;
    logic             mismatch;
    logic             seq_legal;

    assign seq_legal = (succ(seq_in) != 3'b000);

    always_comb begin
        state_n    = state;
        good_n     = good;
        bad_n      = bad;
        expected_n = expected;
        mismatch   = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (seq_legal) begin
                        state_n    = SYNC;
                        good_n     = 4'd1;
                        expected_n = succ(seq_in);
                    end
                end
                SYNC: begin
                    if (seq_in == expected) begin
                        good_n     = good + 4'd1;
                        expected_n = succ(seq_in);
                        if (good + 4'd1 == LOCK_C) begin
                            state_n = LOCKED;
                            bad_n   = 4'd0;
                        end
                    end else if (seq_legal) begin
                        good_n     = 4'd1;
                        expected_n = succ(seq_in);
                    end else begin
                        state_n    = HUNT;
                        good_n     = 4'd0;
                        expected_n = 3'b000;
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances on its own, never re-anchored to the input.
                    expected_n = succ(expected);
                    if (seq_in == expected) begin
                        bad_n = 4'd0;
                    end else begin
                        mismatch = 1'b1;
                        bad_n    = bad + 4'd1;
                        if (bad + 4'd1 == LOSS_C) begin
                            state_n    = HUNT;
                            good_n     = 4'd0;
                            bad_n      = 4'd0;
                            expected_n = 3'b000;
                        end
                    end
                end
                default: begin
                    state_n    = HUNT;
                    good_n     = 4'd0;
                    bad_n      = 4'd0;
                    expected_n = 3'b000;
                end
            endcase
        end

        // A clear coinciding with a new error keeps that error.
        if (clear_err) begin
            err_count_n = mismatch ? ERR_W'(1) : '0;
        end else if (mismatch && err_count != ERR_MAX) begin
            err_count_n = err_count + ERR_W'(1);
        end else begin
            err_count_n = err_count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            good      <= 4'd0;
            bad       <= 4'd0;
            expected  <= 3'b000;
            err_count <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            good      <= good_n;
            bad       <= bad_n;
            expected  <= expected_n;
            err_count <= err_count_n;
            err_pulse <= mismatch;
            locked    <= (state_n == LOCKED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequence_checker.sv
`default_nettype none
// ============================================================================
// tb_sequence_checker : scoreboard bench for sequence_checker
// Rev 1.0
// ============================================================================
module tb_sequence_checker;

    localparam int LOCK = 4;
    localparam int LOSS_A = 3;
    localparam int LOSS_B = 15;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_a = 1'b0, clr_a = 1'b0, en_b = 1'b0, clr_b = 1'b0;
    logic [2:0] seq_a = 3'b000, seq_b = 3'b000;
    logic       locked_a, pulse_a, locked_b, pulse_b;
    logic [7:0] cnt_a, cnt_b;
    logic [2:0] exp_a, exp_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sequence_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS_A), .ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .seq_in(seq_a), .clear_err(clr_a),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a), .expected(exp_a)
    );

    sequence_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS_B), .ERR_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .seq_in(seq_b), .clear_err(clr_b),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b), .expected(exp_b)
    );

    // Reference model: state 0=hunt, 1=sync, 2=locked.
    typedef struct {
        int         st;
        int         good;
        int         bad;
        logic [2:0] exp;
        int         cnt;
        logic       pulse;
    } mdl_t;

    typedef struct {
        int         which;
        logic       locked;
        logic       pulse;
        logic [7:0] cnt;
        logic [2:0] exp;
    } sb_t;

    mdl_t ma, mb;
    sb_t  sbq[$];

    function automatic int code_idx(input logic [2:0] s);
        logic [2:0] codes [4];
        codes[0] = 3'b101; codes[1] = 3'b110; codes[2] = 3'b011; codes[3] = 3'b001;
        for (int i = 0; i < 4; i++) if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [2:0] nxt(input logic [2:0] s);
        logic [2:0] codes [4];
        codes[0] = 3'b101; codes[1] = 3'b110; codes[2] = 3'b011; codes[3] = 3'b001;
        return codes[(code_idx(s) + 1) % 4];
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.st = 0; m.good = 0; m.bad = 0; m.exp = 3'b000; m.cnt = 0; m.pulse = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic en, input logic [2:0] s,
                                   input logic clr, input int loss);
        mdl_t n;
        bit   err;
        n = m;
        n.pulse = 1'b0;
        err = 0;
        if (en) begin
            if (m.st == 0) begin
                if (code_idx(s) >= 0) begin
                    n.st = 1; n.good = 1; n.exp = nxt(s);
                end
            end else if (m.st == 1) begin
                if (s == m.exp) begin
                    n.good = m.good + 1; n.exp = nxt(s);
                    if (n.good == LOCK) begin n.st = 2; n.bad = 0; end
                end else if (code_idx(s) >= 0) begin
                    n.good = 1; n.exp = nxt(s);
                end else begin
                    n.st = 0; n.good = 0; n.exp = 3'b000;
                end
            end else begin
                n.exp = nxt(m.exp);
                if (s == m.exp) n.bad = 0;
                else begin
                    err = 1; n.pulse = 1'b1; n.bad = m.bad + 1;
                    if (n.bad == loss) begin n.st = 0; n.bad = 0; n.good = 0; n.exp = 3'b000; end
                end
            end
        end
        if (clr) n.cnt = err ? 1 : 0;
        else if (err && m.cnt < CMAX) n.cnt = m.cnt + 1;
        return n;
    endfunction

    // Drive one sample on the chosen instance and queue its predicted outputs.
    task automatic step(input int which, input logic en, input logic [2:0] s, input logic clr);
        sb_t e;
        @(negedge clk);
        if (which == 0) begin
            en_a = en; seq_a = s; clr_a = clr;
            ma = mstep(ma, en, s, clr, LOSS_A);
            e = '{0, ma.st == 2, ma.pulse, 8'(ma.cnt), ma.exp};
        end else begin
            en_b = en; seq_b = s; clr_b = clr;
            mb = mstep(mb, en, s, clr, LOSS_B);
            e = '{1, mb.st == 2, mb.pulse, 8'(mb.cnt), mb.exp};
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
        en_a = 1'b0; clr_a = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            sb_t e;
            logic       l, p;
            logic [7:0] c;
            logic [2:0] x;
            e = sbq.pop_front();
            l = e.which == 0 ? locked_a : locked_b;
            p = e.which == 0 ? pulse_a  : pulse_b;
            c = e.which == 0 ? cnt_a    : cnt_b;
            x = e.which == 0 ? exp_a    : exp_b;
            n_cmp++;
            if (l !== e.locked || p !== e.pulse || c !== e.cnt || x !== e.exp) begin
                n_err++;
                $display("FAIL sb dut%0d t=%0t: got locked=%b pulse=%b cnt=%0d exp=%b, want locked=%b pulse=%b cnt=%0d exp=%b",
                         e.which, $time, l, p, c, x, e.locked, e.pulse, e.cnt, e.exp);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ma = mreset();
        mb = mreset();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed_clean(input int which, input int n, input logic [2:0] start);
        logic [2:0] s;
        s = start;
        for (int i = 0; i < n; i++) begin
            step(which, 1'b1, s, 1'b0);
            s = nxt(s);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (locked_a !== 1'b0 || pulse_a !== 1'b0 || cnt_a !== 8'd0 || exp_a !== 3'b000) begin
            n_err++;
            $display("FAIL reset: got locked=%b pulse=%b cnt=%0d exp=%b, want 0 0 0 000",
                     locked_a, pulse_a, cnt_a, exp_a);
        end
    endtask

    task automatic test_lock();
        do_reset();
        feed_clean(0, 4, 3'b101);
        n_cmp++;
        if (locked_a !== 1'b1 || exp_a !== 3'b101 || cnt_a !== 8'd0) begin
            n_err++;
            $display("FAIL lock: got locked=%b exp=%b cnt=%0d, want 1 101 0", locked_a, exp_a, cnt_a);
        end
    endtask

    task automatic test_single_error();
        feed_clean(0, 2, 3'b101);
        step(0, 1'b1, 3'b111, 1'b0);
        step(0, 1'b1, 3'b001, 1'b0);
        step(0, 1'b1, 3'b101, 1'b0);
        n_cmp++;
        if (locked_a !== 1'b1 || cnt_a !== 8'd1 || exp_a !== 3'b110) begin
            n_err++;
            $display("FAIL single_err: got locked=%b cnt=%0d exp=%b, want 1 1 110", locked_a, cnt_a, exp_a);
        end
    endtask

    task automatic test_loss_relock();
        do_reset();
        feed_clean(0, 4, 3'b101);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 3'b000, 1'b0);
        n_cmp++;
        if (locked_a !== 1'b0 || cnt_a !== 8'd3 || exp_a !== 3'b000) begin
            n_err++;
            $display("FAIL loss: got locked=%b cnt=%0d exp=%b, want 0 3 000", locked_a, cnt_a, exp_a);
        end
        feed_clean(0, 4, 3'b011);
        n_cmp++;
        if (locked_a !== 1'b1) begin
            n_err++;
            $display("FAIL relock: got locked=%b, want 1", locked_a);
        end
    endtask

    task automatic test_reanchor();
        do_reset();
        step(0, 1'b1, 3'b101, 1'b0);
        step(0, 1'b1, 3'b110, 1'b0);
        step(0, 1'b1, 3'b001, 1'b0);
        n_cmp++;
        if (locked_a !== 1'b0 || exp_a !== 3'b101) begin
            n_err++;
            $display("FAIL reanchor: got locked=%b exp=%b, want 0 101", locked_a, exp_a);
        end
        step(0, 1'b1, 3'b101, 1'b0);
        step(0, 1'b1, 3'b110, 1'b0);
        n_cmp++;
        if (locked_a !== 1'b0) begin
            n_err++;
            $display("FAIL reanchor_early: got locked=%b, want 0", locked_a);
        end
        step(0, 1'b1, 3'b011, 1'b0);
        n_cmp++;
        if (locked_a !== 1'b1) begin
            n_err++;
            $display("FAIL reanchor_lock: got locked=%b, want 1", locked_a);
        end
    endtask

    task automatic test_en_gaps();
        logic [2:0] s;
        do_reset();
        s = 3'b110;
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, s, 1'b0);
            step(0, 1'b0, 3'b000, 1'b0);
            s = nxt(s);
        end
        n_cmp++;
        if (locked_a !== 1'b1 || exp_a !== 3'b110) begin
            n_err++;
            $display("FAIL en_gaps: got locked=%b exp=%b, want 1 110", locked_a, exp_a);
        end
    endtask

    task automatic test_clear_err();
        do_reset();
        feed_clean(0, 4, 3'b101);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b1, 3'b111, 1'b0);
            step(0, 1'b1, ma.exp, 1'b0);
        end
        n_cmp++;
        if (cnt_a !== 8'd5) begin
            n_err++;
            $display("FAIL pre_clear: got cnt=%0d, want 5", cnt_a);
        end
        step(0, 1'b1, 3'b000, 1'b1);
        n_cmp++;
        if (cnt_a !== 8'd1 || pulse_a !== 1'b1) begin
            n_err++;
            $display("FAIL clear_with_err: got cnt=%0d pulse=%b, want 1 1", cnt_a, pulse_a);
        end
        step(0, 1'b0, 3'b000, 1'b1);
        n_cmp++;
        if (cnt_a !== 8'd0 || locked_a !== 1'b1) begin
            n_err++;
            $display("FAIL clear_alone: got cnt=%0d locked=%b, want 0 1", cnt_a, locked_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        feed_clean(0, 4, 3'b101);
        step(0, 1'b1, 3'b010, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        ma = mreset();
        mb = mreset();
        #1;
        n_cmp++;
        if (locked_a !== 1'b0 || cnt_a !== 8'd0 || exp_a !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got locked=%b cnt=%0d exp=%b, want 0 0 000", locked_a, cnt_a, exp_a);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        feed_clean(1, 4, 3'b101);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 14; i++) step(1, 1'b1, 3'b000, 1'b0);
            step(1, 1'b1, mb.exp, 1'b0);
        end
        n_cmp++;
        if (cnt_b !== 8'd255 || locked_b !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d locked=%b, want 255 1", cnt_b, locked_b);
        end
    endtask

    initial begin
        ma = mreset();
        mb = mreset();
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_reanchor();
        test_en_gaps();
        test_clear_err();
        test_async_reset();
        test_saturation();
        @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
Downstream consumer of the 3-bit cyclic sequence stream 101 -> 110 -> 011 -> 001 -> 101 ... produced by the sequence generator.
Acquires lock on the incoming stream and predicts each next code. While locked it flags and counts mismatches, and drops lock after repeated consecutive errors.
Sits directly after the generator output, as a self-check / link-integrity monitor.

Parameters:
LOCK_COUNT, 4, consecutive correct samples (including the first legal one) required to declare lock; legal range 2..15.
LOSS_COUNT, 3, consecutive mismatches while locked that force loss of lock; legal range 1..15.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  sample strobe; seq_in is evaluated only on edges where en=1.
seq_in  input  3  incoming sequence code.
clear_err  input  1  synchronous clear of err_count.
locked  output  1  registered; 1 while the FSM is in LOCKED.
err_pulse  output  1  registered; one-cycle pulse per mismatch detected in LOCKED.
err_count  output  ERR_W  registered; saturating count of mismatches detected in LOCKED.
expected  output  3  registered; code predicted for the next en sample (000 in HUNT).

Behaviour:
- Reset (async, active-high; clock clk): state=HUNT, locked=0, err_pulse=0, err_count=0, expected=000, good/bad counters=0.
- Legal codes: 101, 110, 011, 001. Successor function: 101->110, 110->011, 011->001, 001->101. Illegal codes: 000, 010, 100, 111.
- en=0: FSM, counters and expected hold. err_pulse=0. clear_err still acts.
- All outputs update on the same edge that samples en=1, so latency is 0 cycles after the sampling edge.
- HUNT:
  - legal seq_in -> SYNC, good=1, expected=succ(seq_in).
  - illegal seq_in -> stay in HUNT.
- SYNC:
  - seq_in==expected: good+1 and expected=succ(seq_in). When good+1 reaches LOCK_COUNT -> LOCKED, locked=1, bad=0.
  - mismatch with legal seq_in: re-anchor; stay in SYNC, good=1, expected=succ(seq_in).
  - mismatch with illegal seq_in -> HUNT, expected=000.
  - No err_pulse and no err_count change in SYNC.
- LOCKED:
  - seq_in==expected: bad=0.
  - mismatch: err_pulse=1 for that cycle, err_count+1 (saturates at 2^ERR_W-1), bad+1.
  - Flywheel: expected=succ(expected) on every en sample, match or not. Do not re-anchor to seq_in.
  - When bad+1 reaches LOSS_COUNT -> HUNT, locked=0, expected=000. The err_pulse for that final mismatch still fires.
- err_pulse is high for exactly one clk cycle per mismatching en sample. Back-to-back mismatches with en held high give a continuous high.
- clear_err and mismatch on the same edge: err_count=1, so the new error is not lost. clear_err alone: err_count=0.
- clear_err does not affect FSM, locked or expected.
- Reset asserted mid-operation: immediate return to reset values regardless of state. err_count is lost.

Test Plan:
- Reset, then en=1 every cycle with seq_in=101,110,011,001 -> locked=1 after the 4th sample edge; expected=101; err_pulse never asserted; err_count=0.
- Locked stream, inject 111 once in place of 011, then resume 001,101 -> single err_pulse, err_count=1, locked stays 1, expected tracks 001 then 101.
- Locked, 3 consecutive wrong codes (000,000,000) -> err_pulse high 3 cycles, err_count=3, locked=0 on the 3rd edge. A clean stream then relocks after 4 samples.
- Before lock: 101,110 then 001 (legal, wrong) -> stays in SYNC with good=1, expected=101. Next 101,110,011 -> locked=1 (lock needs 4 from the 001 anchor).
- en toggled 1/0 with a valid stream -> lock after 4 en=1 samples regardless of gaps; err_count saturates at 255 under a forced 255+ mismatches with LOSS_COUNT=15 and periodic re-matching.
- clear_err asserted on the same edge as a mismatch with err_count=5 -> err_count=1. Async reset pulse while locked -> locked=0, err_count=0 immediately, without waiting for a clock edge.
